// File: rtl/am_demod_pkg.sv
// Shared types and elaboration-time helpers for the AM envelope demodulator.
package am_demod_pkg;

  // Default geometry; the top exposes these as overridable parameters.
  localparam int unsigned W_DEFAULT          = 16;
  localparam int unsigned LOG2_DECIM_DEFAULT = 4;
  localparam int unsigned K_DEFAULT          = 6;

  // Frame-control view of the integrate-and-dump counter and output slot.
  typedef enum logic [1:0] {
    ST_ACCUM,  // mid-frame, sample always accepted
    ST_LAST,   // final sample of frame, output slot free or draining
    ST_STALL   // final sample of frame, output slot occupied and not draining
  } ctrl_state_e;

  function automatic int unsigned decim(input int unsigned log2_decim);
    return 32'd1 << log2_decim;
  endfunction

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2_decim);
    return w + log2_decim;
  endfunction

  function automatic int unsigned dc_width(input int unsigned w, input int unsigned k);
    return w + k;
  endfunction

  function automatic bit params_legal(input int unsigned log2_decim, input int unsigned k);
    return (log2_decim >= 1) && (log2_decim <= 8) && (k >= 1) && (k <= 12);
  endfunction

endpackage

// File: rtl/am_demod_dcblock.sv
// Single-pole DC tracker: removes the carrier level from the recovered envelope.
module am_demod_dcblock
  import am_demod_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_end,
  input  logic [W-1:0] env,
  output logic [W:0]   audio
);

  localparam int DC_W = dc_width(W, K);

  // Unsigned fixed-point estimate with K fractional bits.
  logic [DC_W-1:0]        dc_q, dc_d;
  logic signed [DC_W:0]   diff;
  logic signed [DC_W:0]   step;

  // Leaky update toward env, applied only on frame boundaries.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dc_d = dc_q;
    diff = $signed({1'b0, env, {K{1'b0}}}) - $signed({1'b0, dc_q});
    step = diff >>> K;
    if (frame_end) begin
      dc_d = dc_q + DC_W'(step);
    end
  end

  // Audio uses the estimate from before this frame's update.
  assign audio = {1'b0, env} - {1'b0, dc_q[DC_W-1:K]};

  // Estimate register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      dc_q <= '0;
    end else begin
      dc_q <= dc_d;
    end
  end

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: rectify, integrate-and-dump over DECIM samples,
// then strip the carrier DC level. Valid/ready on both sides.
module am_demod
  import am_demod_pkg::*;
#(
  parameter int W          = 16,
  parameter int LOG2_DECIM = 4,
  parameter int K          = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_env,
  output logic [W:0]   out_audio
);

  localparam int ACC_W = acc_width(W, LOG2_DECIM);
  localparam int DECIM = decim(LOG2_DECIM);
  localparam logic [LOG2_DECIM-1:0] CNT_LAST = LOG2_DECIM'(DECIM - 1);

  if (!params_legal(LOG2_DECIM, K)) begin : g_bad_params
    $error("am_demod: LOG2_DECIM must be 1..8 and K must be 1..12");
  end

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_env_q, out_env_d;
  logic [W:0]            out_audio_q, out_audio_d;

  logic [W-1:0]          abs_val;
  logic [ACC_W-1:0]      acc_sum;
  logic [W-1:0]          env_new;
  logic [W:0]            audio_new;
  logic                  accept;
  logic                  frame_end;
  ctrl_state_e           state;

  // Full-wave rectifier; the most negative input maps to 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    abs_val = in_data[W-1] ? -in_data : in_data;
    acc_sum = acc_q + ACC_W'(abs_val);
    env_new = acc_sum[ACC_W-1:LOG2_DECIM];
  end

  // Frame control: only the last sample of a frame can be stalled by a full output slot.
  always_comb begin
    state = ST_ACCUM;
    if (cnt_q == CNT_LAST) begin
      state = (out_valid_q && !out_ready) ? ST_STALL : ST_LAST;
    end
    in_ready  = (state != ST_STALL);
    accept    = in_valid && in_ready;
    frame_end = accept && (state == ST_LAST);
  end

  am_demod_dcblock #(
    .W (W),
    .K (K)
  ) u_dcblock (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .env       (env_new),
    .audio     (audio_new)
  );

  // Next-state for accumulator, counter and the single output slot.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_env_d   = out_env_q;
    out_audio_d = out_audio_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (frame_end) begin
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_env_d   = env_new;
        out_audio_d = audio_new;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath and slot registers; reset drops any partial frame and pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_env_q   <= '0;
      out_audio_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_env_q   <= out_env_d;
      out_audio_q <= out_audio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_env   = out_env_q;
  assign out_audio = out_audio_q;

endmodule

// File: tb/tb_am_demod.sv
// Self-checking bench for am_demod: directed frames with hand-computed
// envelope/audio values plus a randomised AM run against a reference model.
module tb_am_demod;

  localparam int W     = 16;
  localparam int L     = 4;
  localparam int K     = 6;
  localparam int DECIM = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_env;
  logic [W:0]   out_audio;

  int n_checks = 0;
  int n_fail   = 0;

  int rx_env[$];
  int rx_aud[$];
  int exp_env[$];
  int exp_aud[$];
  int n_acc_samples = 0;
  int n_out         = 0;
  bit rand_phase    = 1'b0;

  always #5 clk = ~clk;

  am_demod #(
    .W          (W),
    .LOG2_DECIM (L),
    .K          (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_env   (out_env),
    .out_audio (out_audio)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: samples handshakes mid-cycle, runs the reference model, checks every output word.
  initial begin : monitor
    int x, absx, env, aud, e, a;
    int m_acc, m_cnt, m_dc;
    m_acc = 0; m_cnt = 0; m_dc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_acc = 0; m_cnt = 0; m_dc = 0;
        exp_env.delete();
        exp_aud.delete();
      end else begin
        if (out_valid && out_ready) begin
          rx_env.push_back(int'(out_env));
          rx_aud.push_back(int'($signed(out_audio)));
          n_out++;
          check("model_has_expect", int'(exp_env.size() != 0), 1);
          if (exp_env.size() != 0) begin
            e = exp_env.pop_front();
            a = exp_aud.pop_front();
            check("model_env", int'(out_env), e);
            check("model_audio", int'($signed(out_audio)), a);
          end
        end
        if (in_valid && in_ready) begin
          n_acc_samples++;
          x = int'($signed(in_data));
          absx = (x < 0) ? -x : x;
          m_acc += absx;
          m_cnt++;
          if (m_cnt == DECIM) begin
            env  = m_acc / DECIM;
            aud  = env - (m_dc >>> K);
            m_dc = m_dc + (((env << K) - m_dc) >>> K);
            exp_env.push_back(env);
            exp_aud.push_back(aud);
            m_acc = 0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  // Random backpressure, active only during the randomised phase.
  initial begin : ready_gen
    forever begin
      @(negedge clk);
      if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "tb_am_demod timeout");
  end

  task automatic put(input int d, input int max_gap);
    int t;
    if (max_gap > 0) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d[W-1:0];
    #1;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rx_env.delete();
    rx_aud.delete();
  endtask

  task automatic frame(input int d);
    for (int i = 0; i < DECIM; i++) put(d, 0);
  endtask

  task automatic expect_out(input string tag, input int env, input int aud);
    int t;
    t = 0;
    while (rx_env.size() == 0 && t < 200) begin
      @(negedge clk);
      #3;
      t++;
    end
    check({tag, "_present"}, int'(rx_env.size() != 0), 1);
    if (rx_env.size() != 0) begin
      check({tag, "_env"}, rx_env.pop_front(), env);
      check({tag, "_audio"}, rx_aud.pop_front(), aud);
    end
  endtask

  initial begin : stim
    int a0, o0, amp, x;
    int sin_tab[8];
    sin_tab = '{0, 707, 1000, 707, 0, -707, -1000, -707};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_env", int'(out_env), 0);
    check("rst_out_audio", int'($signed(out_audio)), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Constant +1000: latency, envelope, DC decay of audio.
    for (int i = 0; i < DECIM; i++) put(1000, 0);
    check("lat_not_early", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_valid", int'(out_valid), 1);
    check("lat_env", int'(out_env), 1000);
    expect_out("const1", 1000, 1000);
    frame(1000);
    expect_out("const2", 1000, 985);
    frame(1000);
    expect_out("const3", 1000, 969);

    // Alternating +/-2000: rectifier.
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < DECIM; i++) put((i % 2) ? -2000 : 2000, 0);
    expect_out("alt1", 2000, 2000);
    expect_out("alt2", 2000, 1969);

    // Most negative input: no wrap.
    do_reset();
    frame(-32768);
    frame(-32768);
    expect_out("neg1", 32768, 32768);
    expect_out("neg2", 32768, 32256);

    // Backpressure on the last sample of a frame.
    do_reset();
    out_ready = 1'b0;
    frame(100);
    idle(1);
    #1;
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_env", int'(out_env), 100);
    for (int i = 0; i < DECIM - 1; i++) put(300, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd300;
    #1;
    check("bp_stall_ready", int'(in_ready), 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("bp_stall_ready_held", int'(in_ready), 0);
      check("bp_stable_env", int'(out_env), 100);
      check("bp_stable_audio", int'($signed(out_audio)), 100);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_second_valid", int'(out_valid), 1);
    check("bp_second_env", int'(out_env), 300);
    check("bp_second_audio", int'($signed(out_audio)), 299);
    expect_out("bp1", 100, 100);
    expect_out("bp2", 300, 299);

    // Reset mid-frame with a pending output word.
    do_reset();
    out_ready = 1'b0;
    frame(500);
    for (int i = 0; i < 7; i++) put(5000, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_env", int'(out_env), 0);
    check("mid_rst_audio", int'($signed(out_audio)), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    rx_env.delete();
    rx_aud.delete();
    out_ready = 1'b1;
    frame(700);
    idle(3);
    check("mid_rst_count", rx_env.size(), 1);
    expect_out("mid_rst", 700, 700);

    // Random AM with input gaps and output backpressure against the model.
    do_reset();
    a0 = n_acc_samples;
    o0 = n_out;
    rand_phase = 1'b1;
    for (int i = 0; i < 20 * DECIM; i++) begin
      amp = 8000 + (4000 * sin_tab[(i / DECIM) % 8]) / 1000 + int'($urandom_range(0, 63));
      x   = (i % 2) ? amp : -amp;
      put(x, 2);
    end
    idle(1);
    rand_phase = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    idle(10);
    check("conserve_accepted", n_acc_samples - a0, 20 * DECIM);
    check("conserve_outputs", n_out - o0, 20);
    check("model_drained", exp_env.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
